wbd_core_arb: RTL and testbench
===============================

Name: wbd_core_arb

Overview:
- Two-master to one-slave Wishbone arbiter for the RISC-V core cluster.
- Shares one Wishbone data port between the core's instruction-memory master (imem) and data-memory master (dmem).
- Round-robin grant, grant held for exactly one transaction, and a bus-hang timeout that returns an error to the stalled master.
- Sits between the core's Wishbone wrapper and the interconnect.

Parameters:
- TOUT_W, 8, width of timeout counter; timeout fires after 2^TOUT_W-1 cycles in BUSY without ack/err.
- TOUT_EN, 1, 1 enables timeout; 0 means wait forever.

Ports:
- wb_clk  input  1  Wishbone clock; all logic on rising edge.
- wb_rst  input  1  synchronous, active-high reset.
- wbd_imem_stb_i  input  1  imem request.
- wbd_imem_we_i  input  1  imem write enable.
- wbd_imem_adr_i  input  32  imem address.
- wbd_imem_dat_i  input  32  imem write data.
- wbd_imem_sel_i  input  4  imem byte select.
- wbd_imem_dat_o  output  32  imem read data.
- wbd_imem_ack_o  output  1  imem ack.
- wbd_imem_err_o  output  1  imem error.
- wbd_dmem_*  same set as imem  -  dmem master port.
- wbd_cyc_o  output  1  slave cycle.
- wbd_stb_o  output  1  slave strobe.
- wbd_we_o  output  1  slave write enable.
- wbd_adr_o  output  32  slave address.
- wbd_dat_o  output  32  slave write data.
- wbd_sel_o  output  4  slave byte select.
- wbd_dat_i  input  32  slave read data.
- wbd_ack_i  input  1  slave ack.
- wbd_err_i  input  1  slave error.
- arb_gnt_o  output  2  one-hot grant: bit0 imem, bit1 dmem; 00 when idle.
- tout_o  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset (wb_rst=1 at a clock edge):
  - state=IDLE, arb_gnt_o=00, last=dmem, timeout counter=0.
  - All slave outputs 0; tout_o=0.
  - Any in-flight transaction is abandoned; no ack/err is generated for it.
- States are IDLE and BUSY.
- IDLE:
  - Slave outputs are 0.
  - Arbitration:
    - Only imem stb high: grant imem.
    - Only dmem stb high: grant dmem.
    - Both high: grant the master not equal to last.
  - The grant is registered; the state goes BUSY at the next edge.
  - Arbitration latency is 1 cycle from stb to slave stb.
- BUSY:
  - wbd_cyc_o=wbd_stb_o=1.
  - we/adr/dat/sel are a combinational mux of the granted master's inputs.
  - Counter increments every cycle.
- Response routing:
  - wbd_dat_i fans out to both masters' dat_o unconditionally.
  - ack/err are forwarded combinationally only to the granted master, gated by BUSY.
  - The ungranted master's ack/err stay 0.
- Completion: wbd_ack_i or wbd_err_i in BUSY causes:
  - transition to IDLE at that edge;
  - last=granted master;
  - counter cleared;
  - arb_gnt_o=00.
- If ack and err are both high, both are forwarded and the cycle counts as completion.
- Back-to-back: at least one IDLE cycle occurs between transactions. Max throughput is one transaction per 2 cycles with a zero-wait slave.
- Abort: if the granted master drops stb in BUSY with no ack/err, go IDLE with no response. last is still updated.
- Timeout (TOUT_EN=1): when the counter reaches 2^TOUT_W-1 with no ack/err that cycle:
  - err is asserted to the granted master for that cycle;
  - tout_o=1 for that cycle;
  - the state goes IDLE; cyc/stb drop at the next edge.
- A real ack/err arriving in the same cycle as the timeout takes precedence: no tout_o, the real response is forwarded.
- Slave responses arriving in IDLE (late ack after a timeout) are ignored and not forwarded.
- Masters must hold stb and request fields stable until ack/err; the arbiter does not latch request fields.

Test Plan:
- Single imem read:
  - Stimulus: imem stb, adr=0x0000_1000; slave acks 2 cycles after stb_o with dat=0xDEAD_BEEF.
  - Required: wbd_stb_o rises 1 cycle after imem stb; imem ack_o=1 with dat 0xDEADBEEF; dmem ack stays 0; arb_gnt_o 01→00.
- Simultaneous requests after reset:
  - Stimulus: imem and dmem stb high in the same cycle.
  - Required: imem granted first (last=dmem at reset), then dmem. Sustained contention for 8 transactions alternates imem, dmem, imem, ...
- dmem write:
  - Stimulus: dmem we=1, sel=0x3, dat=0x1234_5678, adr=0x3000_0004.
  - Required: slave sees identical we/sel/dat/adr; ack is routed only to dmem.
- Timeout with TOUT_W=4:
  - Stimulus: slave never acks.
  - Required: after 15 BUSY cycles, imem err_o=1 and tout_o=1 for one cycle; cyc_o drops next cycle; a late slave ack in IDLE produces no master ack.
- Reset mid-transaction:
  - Stimulus: wb_rst=1 while BUSY.
  - Required: next cycle all slave outputs 0, arb_gnt_o=00; after release, a pending dmem-only request is granted within 1 cycle.
- Error and abort:
  - Stimulus: slave err on a dmem read.
  - Required: dmem err_o=1, ack_o=0, arbiter returns to IDLE.
  - Stimulus: granted master drops stb mid-BUSY.
  - Required: IDLE next cycle, no response generated.

Source files
------------

// File: rtl/wbd_core_arb_if.sv
// Wishbone bundle around wbd_core_arb: the imem and dmem master ports plus the shared slave port.
// Modport slave is the arbiter's view; modport master is the core wrapper / interconnect side.
interface wbd_core_arb_if;
  logic        wbd_imem_stb_i;
  logic        wbd_imem_we_i;
  logic [31:0] wbd_imem_adr_i;
  logic [31:0] wbd_imem_dat_i;
  logic [3:0]  wbd_imem_sel_i;
  logic [31:0] wbd_imem_dat_o;
  logic        wbd_imem_ack_o;
  logic        wbd_imem_err_o;

  logic        wbd_dmem_stb_i;
  logic        wbd_dmem_we_i;
  logic [31:0] wbd_dmem_adr_i;
  logic [31:0] wbd_dmem_dat_i;
  logic [3:0]  wbd_dmem_sel_i;
  logic [31:0] wbd_dmem_dat_o;
  logic        wbd_dmem_ack_o;
  logic        wbd_dmem_err_o;

  logic        wbd_cyc_o;
  logic        wbd_stb_o;
  logic        wbd_we_o;
  logic [31:0] wbd_adr_o;
  logic [31:0] wbd_dat_o;
  logic [3:0]  wbd_sel_o;
  logic [31:0] wbd_dat_i;
  logic        wbd_ack_i;
  logic        wbd_err_i;

  modport slave (
    input  wbd_imem_stb_i, wbd_imem_we_i, wbd_imem_adr_i, wbd_imem_dat_i, wbd_imem_sel_i,
    output wbd_imem_dat_o, wbd_imem_ack_o, wbd_imem_err_o,
    input  wbd_dmem_stb_i, wbd_dmem_we_i, wbd_dmem_adr_i, wbd_dmem_dat_i, wbd_dmem_sel_i,
    output wbd_dmem_dat_o, wbd_dmem_ack_o, wbd_dmem_err_o,
    output wbd_cyc_o, wbd_stb_o, wbd_we_o, wbd_adr_o, wbd_dat_o, wbd_sel_o,
    input  wbd_dat_i, wbd_ack_i, wbd_err_i
  );

  modport master (
    output wbd_imem_stb_i, wbd_imem_we_i, wbd_imem_adr_i, wbd_imem_dat_i, wbd_imem_sel_i,
    input  wbd_imem_dat_o, wbd_imem_ack_o, wbd_imem_err_o,
    output wbd_dmem_stb_i, wbd_dmem_we_i, wbd_dmem_adr_i, wbd_dmem_dat_i, wbd_dmem_sel_i,
    input  wbd_dmem_dat_o, wbd_dmem_ack_o, wbd_dmem_err_o,
    input  wbd_cyc_o, wbd_stb_o, wbd_we_o, wbd_adr_o, wbd_dat_o, wbd_sel_o,
    output wbd_dat_i, wbd_ack_i, wbd_err_i
  );
endinterface

// File: rtl/wbd_core_arb.sv
// Round-robin two-master (imem/dmem) to one-slave Wishbone arbiter with one-transaction grants
// and a bus-hang timeout that returns an error to the stalled master.
module wbd_core_arb #(
  parameter int TOUT_W  = 8,
  parameter bit TOUT_EN = 1'b1
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  wbd_core_arb_if.slave io_wbd,
  output logic [1:0]    arb_gnt_o,
  output logic          tout_o
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam logic [TOUT_W-1:0] TOUT_MAX = '1;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_gnt, w_gnt_nxt;
  logic              r_last, w_last_nxt;
  logic [TOUT_W-1:0] r_cnt, w_cnt_nxt;

  logic w_busy;
  logic w_sel_dmem;
  logic w_req_stb;
  logic w_resp;
  logic w_tout;
  logic w_imem_stb;
  logic w_dmem_stb;

  assign w_imem_stb = io_wbd.wbd_imem_stb_i;
  assign w_dmem_stb = io_wbd.wbd_dmem_stb_i;
  assign w_busy     = (r_state == ST_BUSY);
  assign w_sel_dmem = r_gnt[1];
  assign w_req_stb  = w_sel_dmem ? w_dmem_stb : w_imem_stb;
  assign w_resp     = io_wbd.wbd_ack_i | io_wbd.wbd_err_i;

  // A real ack/err in the terminal count cycle wins over the timeout.
  assign w_tout = TOUT_EN && w_busy && !w_resp && (r_cnt == TOUT_MAX);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // r_last: 0 = imem won last, 1 = dmem won last; contention goes to the other one.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_imem_stb && w_dmem_stb) begin
          w_gnt_nxt = r_last ? 2'b01 : 2'b10;
        end else if (w_imem_stb) begin
          w_gnt_nxt = 2'b01;
        end else if (w_dmem_stb) begin
          w_gnt_nxt = 2'b10;
        end else begin
          w_gnt_nxt = 2'b00;
        end
        if (w_imem_stb || w_dmem_stb) begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_resp || w_tout || !w_req_stb) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 2'b00;
          w_last_nxt  = w_sel_dmem;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 2'b00;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign io_wbd.wbd_cyc_o = w_busy;
  assign io_wbd.wbd_stb_o = w_busy;
  assign io_wbd.wbd_we_o  = w_busy & (w_sel_dmem ? io_wbd.wbd_dmem_we_i : io_wbd.wbd_imem_we_i);
  assign io_wbd.wbd_adr_o = !w_busy ? 32'h0 :
                            (w_sel_dmem ? io_wbd.wbd_dmem_adr_i : io_wbd.wbd_imem_adr_i);
  assign io_wbd.wbd_dat_o = !w_busy ? 32'h0 :
                            (w_sel_dmem ? io_wbd.wbd_dmem_dat_i : io_wbd.wbd_imem_dat_i);
  assign io_wbd.wbd_sel_o = !w_busy ? 4'h0 :
                            (w_sel_dmem ? io_wbd.wbd_dmem_sel_i : io_wbd.wbd_imem_sel_i);

  // Read data fans out to both masters; only the strobes are qualified by the grant.
  assign io_wbd.wbd_imem_dat_o = io_wbd.wbd_dat_i;
  assign io_wbd.wbd_dmem_dat_o = io_wbd.wbd_dat_i;
  assign io_wbd.wbd_imem_ack_o = w_busy & r_gnt[0] & io_wbd.wbd_ack_i;
  assign io_wbd.wbd_imem_err_o = w_busy & r_gnt[0] & (io_wbd.wbd_err_i | w_tout);
  assign io_wbd.wbd_dmem_ack_o = w_busy & r_gnt[1] & io_wbd.wbd_ack_i;
  assign io_wbd.wbd_dmem_err_o = w_busy & r_gnt[1] & (io_wbd.wbd_err_i | w_tout);

  assign arb_gnt_o = r_gnt;
  assign tout_o    = w_tout;

endmodule

// File: tb/tb_wbd_core_arb.sv
// Self-checking bench for wbd_core_arb: a directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level reference model.
module tb_wbd_core_arb;

  localparam int TW       = 4;
  localparam int TOUT_CYC = (1 << TW) - 1;

  logic       wb_clk = 1'b0;
  logic       wb_rst;
  logic [1:0] arb_gnt_o;
  logic       tout_o;

  wbd_core_arb_if bus();

  wbd_core_arb #(.TOUT_W(TW), .TOUT_EN(1'b1)) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .io_wbd   (bus),
    .arb_gnt_o(arb_gnt_o),
    .tout_o   (tout_o)
  );

  always #5 wb_clk = ~wb_clk;

  int nCompared = 0;
  int nFailed   = 0;

  logic        iWe, dWe;
  logic [31:0] iAdr, iDat, dAdr, dDat, slvDat;
  logic [3:0]  iSel, dSel;

  typedef struct {
    bit         rst, istb, dstb, ack, err;
    logic [1:0] gnt;
    logic [4:0] resp;  // {imem ack, imem err, dmem ack, dmem err, tout}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(bit rst, bit istb, bit dstb, bit ack, bit err,
                                 logic [1:0] gnt, logic [4:0] resp);
    vec_t v;
    v.rst = rst; v.istb = istb; v.dstb = dstb; v.ack = ack; v.err = err;
    v.gnt = gnt; v.resp = resp;
    return v;
  endfunction

  task automatic applyStimulus(input bit rst, input bit istb, input bit dstb,
                               input bit ack, input bit err);
    wb_rst             = rst;
    bus.wbd_imem_stb_i = istb;
    bus.wbd_imem_we_i  = iWe;
    bus.wbd_imem_adr_i = iAdr;
    bus.wbd_imem_dat_i = iDat;
    bus.wbd_imem_sel_i = iSel;
    bus.wbd_dmem_stb_i = dstb;
    bus.wbd_dmem_we_i  = dWe;
    bus.wbd_dmem_adr_i = dAdr;
    bus.wbd_dmem_dat_i = dDat;
    bus.wbd_dmem_sel_i = dSel;
    bus.wbd_dat_i      = slvDat;
    bus.wbd_ack_i      = ack;
    bus.wbd_err_i      = err;
  endtask

  task automatic stepCycle(input bit rst, input bit istb, input bit dstb,
                           input bit ack, input bit err);
    @(negedge wb_clk);
    applyStimulus(rst, istb, dstb, ack, err);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [71:0] got, input logic [71:0] exp);
    nCompared++;
    if (got !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [70:0] expBus(int owner);
    if (owner == 0) return {1'b1, 1'b1, iWe, iSel, iAdr, iDat};
    if (owner == 1) return {1'b1, 1'b1, dWe, dSel, dAdr, dDat};
    return '0;
  endfunction

  function automatic logic [70:0] dutBus();
    return {bus.wbd_cyc_o, bus.wbd_stb_o, bus.wbd_we_o, bus.wbd_sel_o, bus.wbd_adr_o, bus.wbd_dat_o};
  endfunction

  function automatic logic [4:0] dutResp();
    return {bus.wbd_imem_ack_o, bus.wbd_imem_err_o, bus.wbd_dmem_ack_o, bus.wbd_dmem_err_o, tout_o};
  endfunction

  task automatic checkCycle(input string name, input logic [1:0] gnt, input logic [4:0] resp);
    int owner;
    owner = (gnt == 2'b01) ? 0 : (gnt == 2'b10) ? 1 : -1;
    checkOutput({name, ".gnt"}, 72'(arb_gnt_o), 72'(gnt));
    checkOutput({name, ".bus"}, 72'(dutBus()), 72'(expBus(owner)));
    checkOutput({name, ".resp"}, 72'(dutResp()), 72'(resp));
    checkOutput({name, ".rdat"}, 72'({bus.wbd_imem_dat_o, bus.wbd_dmem_dat_o}), 72'({slvDat, slvDat}));
  endtask

  // Reference model state: who owns the bus (-1 none), BUSY cycles so far, last winner.
  int  owner, age, last;
  bit  iReq, dReq, iGotResp, dGotResp, slowMode;

  initial begin
    iWe = 1'b0; iAdr = 32'h0000_1000; iDat = 32'h0; iSel = 4'hF;
    dWe = 1'b1; dAdr = 32'h3000_0004; dDat = 32'h1234_5678; dSel = 4'h3;
    slvDat = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    vecs.push_back(mkVec(1, 0, 0, 0, 0, 2'b00, 5'b00000));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 2'b00, 5'b00000));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 2'b01, 5'b00000));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 2'b01, 5'b00000));
    vecs.push_back(mkVec(0, 1, 0, 1, 0, 2'b01, 5'b10000));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 2'b00, 5'b00000));
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 2'b00, 5'b00000));
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 2'b10, 5'b00000));
    vecs.push_back(mkVec(0, 0, 1, 1, 0, 2'b10, 5'b00100));
    vecs.push_back(mkVec(0, 0, 0, 1, 0, 2'b00, 5'b00000));
    vecs.push_back(mkVec(0, 1, 1, 0, 0, 2'b00, 5'b00000));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 2'b01, 5'b10000));
    vecs.push_back(mkVec(0, 1, 1, 0, 0, 2'b00, 5'b00000));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 2'b10, 5'b00100));
    vecs.push_back(mkVec(0, 1, 1, 0, 0, 2'b00, 5'b00000));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 2'b01, 5'b10000));
    vecs.push_back(mkVec(0, 1, 1, 0, 0, 2'b00, 5'b00000));
    vecs.push_back(mkVec(0, 1, 1, 0, 1, 2'b10, 5'b00010));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 2'b00, 5'b00000));
    vecs.push_back(mkVec(0, 1, 0, 0, 0, 2'b00, 5'b00000));
    vecs.push_back(mkVec(0, 1, 0, 1, 1, 2'b01, 5'b11000));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 2'b00, 5'b00000));

    for (int i = 0; i < vecs.size(); i++) begin
      stepCycle(vecs[i].rst, vecs[i].istb, vecs[i].dstb, vecs[i].ack, vecs[i].err);
      checkCycle($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].resp);
    end

    // Timeout on imem: error and tout in the terminal BUSY cycle only, late ack ignored.
    stepCycle(0, 1, 0, 0, 0);
    checkCycle("tout.idle", 2'b00, 5'b00000);
    for (int b = 0; b <= TOUT_CYC; b++) begin
      stepCycle(0, 1, 0, 0, 0);
      checkCycle($sformatf("tout.busy%0d", b), 2'b01, (b == TOUT_CYC) ? 5'b01001 : 5'b00000);
    end
    stepCycle(0, 0, 0, 1, 0);
    checkCycle("tout.lateack", 2'b00, 5'b00000);

    // Real ack in the terminal cycle beats the timeout.
    stepCycle(0, 0, 1, 0, 0);
    checkCycle("toutack.idle", 2'b00, 5'b00000);
    for (int b = 0; b < TOUT_CYC; b++) begin
      stepCycle(0, 0, 1, 0, 0);
      checkCycle($sformatf("toutack.busy%0d", b), 2'b10, 5'b00000);
    end
    stepCycle(0, 0, 1, 1, 0);
    checkCycle("toutack.last", 2'b10, 5'b00100);
    stepCycle(0, 0, 0, 0, 0);
    checkCycle("toutack.after", 2'b00, 5'b00000);

    // Reset while BUSY, then a pending dmem request is granted straight away.
    stepCycle(0, 0, 1, 0, 0);
    checkCycle("rst.idle", 2'b00, 5'b00000);
    stepCycle(0, 0, 1, 0, 0);
    checkCycle("rst.busy", 2'b10, 5'b00000);
    stepCycle(1, 0, 1, 0, 0);
    checkCycle("rst.assert", 2'b10, 5'b00000);
    stepCycle(0, 0, 1, 0, 0);
    checkCycle("rst.cleared", 2'b00, 5'b00000);
    stepCycle(0, 0, 1, 1, 0);
    checkCycle("rst.regrant", 2'b10, 5'b00100);

    // Abort by imem: no response, and imem still counts as the last winner.
    stepCycle(0, 1, 0, 0, 0);
    checkCycle("abort.idle", 2'b00, 5'b00000);
    stepCycle(0, 1, 0, 0, 0);
    checkCycle("abort.busy", 2'b01, 5'b00000);
    stepCycle(0, 0, 0, 0, 0);
    checkCycle("abort.drop", 2'b01, 5'b00000);
    stepCycle(0, 1, 1, 0, 0);
    checkCycle("abort.after", 2'b00, 5'b00000);
    stepCycle(0, 1, 1, 1, 0);
    checkCycle("abort.nextgnt", 2'b10, 5'b00100);

    // Sustained contention with a zero-wait slave alternates, one transaction every 2 cycles.
    for (int t = 0; t < 8; t++) begin
      stepCycle(0, 1, 1, 0, 0);
      checkCycle($sformatf("rr%0d.idle", t), 2'b00, 5'b00000);
      stepCycle(0, 1, 1, 1, 0);
      checkCycle($sformatf("rr%0d.busy", t), (t % 2 == 0) ? 2'b01 : 2'b10,
                 (t % 2 == 0) ? 5'b10000 : 5'b00100);
    end
    stepCycle(0, 0, 0, 0, 0);

    // Randomized traffic against the reference model.
    owner = -1; age = 0; last = 1;
    iReq = 0; dReq = 0; iGotResp = 0; dGotResp = 0; slowMode = 0;
    for (int c = 0; c < 3000; c++) begin
      bit rst, ack, err, toutNow, stbOwner;
      logic [1:0] eGnt;
      logic [4:0] eResp;
      rst = (c == 0) || ($urandom_range(0, 299) == 0);
      if (c % 100 == 0) slowMode = ($urandom_range(0, 2) == 0);
      if (iReq) begin
        if (iGotResp || $urandom_range(0, 59) == 0) begin
          iReq = ($urandom_range(0, 1) == 1);
          if (iReq) begin iWe = $urandom(); iAdr = $urandom(); iDat = $urandom(); iSel = $urandom(); end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        iReq = 1;
        iWe = $urandom(); iAdr = $urandom(); iDat = $urandom(); iSel = $urandom();
      end
      if (dReq) begin
        if (dGotResp || $urandom_range(0, 59) == 0) begin
          dReq = ($urandom_range(0, 1) == 1);
          if (dReq) begin dWe = $urandom(); dAdr = $urandom(); dDat = $urandom(); dSel = $urandom(); end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        dReq = 1;
        dWe = $urandom(); dAdr = $urandom(); dDat = $urandom(); dSel = $urandom();
      end
      ack = 0; err = 0;
      if (slowMode ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0)) begin
        err = ($urandom_range(0, 7) == 0);
        ack = !err || ($urandom_range(0, 3) == 0);
      end
      slvDat = $urandom();
      stepCycle(rst, iReq, dReq, ack, err);

      eGnt = 2'b00; eResp = 5'b00000; toutNow = 0;
      if (owner >= 0) begin
        eGnt = (owner == 0) ? 2'b01 : 2'b10;
        toutNow = !(ack || err) && (age == TOUT_CYC);
        if (owner == 0) eResp = {ack, err || toutNow, 1'b0, 1'b0, toutNow};
        else            eResp = {1'b0, 1'b0, ack, err || toutNow, toutNow};
      end
      checkCycle($sformatf("rand%0d", c), eGnt, eResp);
      iGotResp = (owner == 0) && (ack || err || toutNow);
      dGotResp = (owner == 1) && (ack || err || toutNow);

      if (rst) begin
        owner = -1; age = 0; last = 1;
      end else if (owner < 0) begin
        if (iReq && dReq) owner = 1 - last;
        else if (iReq)    owner = 0;
        else if (dReq)    owner = 1;
        age = 0;
      end else begin
        stbOwner = (owner == 0) ? iReq : dReq;
        if (ack || err || toutNow || !stbOwner) begin
          last = owner; owner = -1; age = 0;
        end else begin
          age++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
